// File: rtl/max_tree_with_index_if.sv
// Stream bundle for the arg-max/arg-min tree: one request channel in, one result channel out.
interface max_tree_with_index_if #(
    parameter int unsigned C_DATA_WIDTH  = 8,
    parameter int unsigned C_INDEX_WIDTH = 3
);
    localparam int unsigned N = 1 << C_INDEX_WIDTH;

    logic                        in_valid;
    logic                        in_ready;
    logic [N*C_DATA_WIDTH-1:0]   in_data;
    logic [N-1:0]                in_mask;
    logic                        in_min;
    logic                        out_valid;
    logic                        out_ready;
    logic [C_DATA_WIDTH-1:0]     out_data;
    logic [C_INDEX_WIDTH-1:0]    out_index;
    logic                        out_none;

    // Requester side: presents lanes, consumes results.
    modport master (
        output in_valid, in_data, in_mask, in_min, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_none
    );

    // Reduction tree side.
    modport slave (
        input  in_valid, in_data, in_mask, in_min, out_ready,
        output in_ready, out_valid, out_data, out_index, out_none
    );
endinterface

// File: rtl/max_tree_with_index.sv
// Pipelined N-lane arg-max/arg-min tree, one register stage per level, valid/ready with bubble collapse.
module max_tree_with_index #(
    parameter int unsigned C_DATA_WIDTH  = 8,
    parameter int unsigned C_INDEX_WIDTH = 3,
    parameter bit          C_SIGNED      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    max_tree_with_index_if.slave bus
);
    localparam int unsigned W  = C_DATA_WIDTH;
    localparam int unsigned IW = C_INDEX_WIDTH;
    localparam int unsigned L  = C_INDEX_WIDTH;
    localparam int unsigned N  = 1 << C_INDEX_WIDTH;

    // Internal nodes in heap order 1..N-1; node i has children 2i (lower lanes) and 2i+1.
    // Node i sits in stage L - floor(log2(i)); the root (node 1) is the last stage.
    logic [W-1:0]  dat_q  [1:N-1];
    logic [W-1:0]  dat_d  [1:N-1];
    logic [IW-1:0] idx_q  [1:N-1];
    logic [IW-1:0] idx_d  [1:N-1];
    logic          live_q [1:N-1];
    logic          live_d [1:N-1];

    // Combined view: registered nodes 2..N-1 plus leaves N..2N-1 taken straight from the inputs.
    logic [W-1:0]  all_dat  [2:2*N-1];
    logic [IW-1:0] all_idx  [2:2*N-1];
    logic          all_live [2:2*N-1];

    logic [L:1]    v_q;
    logic [L:1]    v_d;
    logic [L:1]    up_v_c;
    logic [L:1]    load_c;
    logic [L-1:0]  rdy_c;
    logic [L-1:0]  min_src_c;

    function automatic logic a_beats_b(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic mn);
        logic gt;
        logic lt;
        if (C_SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return mn ? lt : gt;
    endfunction

    // Ready chain: a stage can load when it is empty or everything downstream of it can move.
    always_comb begin : p_flow
        logic acc;
        acc       = bus.out_ready;
        rdy_c     = '0;
        up_v_c    = '0;
        load_c    = '0;
        v_d       = v_q;
        for (int s = int'(L); s >= 1; s--) begin
            acc        = acc | ~v_q[s];
            rdy_c[s-1] = acc;
        end
        up_v_c[1] = bus.in_valid;
        for (int s = 2; s <= int'(L); s++) begin
            up_v_c[s] = v_q[s-1];
        end
        for (int s = 1; s <= int'(L); s++) begin
            load_c[s] = rdy_c[s-1] & up_v_c[s];
            if (rdy_c[s-1]) begin
                v_d[s] = up_v_c[s];
            end
        end
    end

    // Mode bit travels with every stage except the root, whose result needs no further compare.
    if (L > 1) begin : g_mode
        logic [L-2:0] min_q;

        // Capture the min/max mode together with the stage payload.
        always_ff @(posedge clk) begin
            if (rst) begin
                min_q <= '0;
            end else begin
                for (int s = 1; s < int'(L); s++) begin
                    if (load_c[s]) begin
                        min_q[s-1] <= min_src_c[s-1];
                    end
                end
            end
        end

        assign min_src_c = {min_q, bus.in_min};
    end else begin : g_mode_root
        assign min_src_c = bus.in_min;
    end

    // Next node values: pick the live child, or the strictly better one; ties go to the upper child.
    always_comb begin : p_tree
        int   nd;
        logic a_live;
        logic b_live;
        logic a_win;
        nd     = 0;
        a_live = 1'b0;
        b_live = 1'b0;
        a_win  = 1'b0;
        for (int j = 1; j < int'(N); j++) begin
            dat_d[j]  = '0;
            idx_d[j]  = '0;
            live_d[j] = 1'b0;
        end
        for (int k = 0; k < int'(N); k++) begin
            all_dat[int'(N) + k]  = bus.in_data[k*W +: W];
            all_idx[int'(N) + k]  = IW'(k);
            all_live[int'(N) + k] = bus.in_mask[k];
        end
        for (int j = 2; j < int'(N); j++) begin
            all_dat[j]  = dat_q[j];
            all_idx[j]  = idx_q[j];
            all_live[j] = live_q[j];
        end
        for (int s = 1; s <= int'(L); s++) begin
            for (int m = 0; m < int'(N >> s); m++) begin
                nd     = int'(N >> s) + m;
                a_live = all_live[2*nd];
                b_live = all_live[2*nd+1];
                a_win  = a_live & (~b_live |
                         a_beats_b(all_dat[2*nd], all_dat[2*nd+1], min_src_c[s-1]));
                live_d[nd] = a_live | b_live;
                if (a_win) begin
                    dat_d[nd] = all_dat[2*nd];
                    idx_d[nd] = all_idx[2*nd];
                end else if (b_live) begin
                    dat_d[nd] = all_dat[2*nd+1];
                    idx_d[nd] = all_idx[2*nd+1];
                end else begin
                    dat_d[nd] = '0;
                    idx_d[nd] = '0;
                end
            end
        end
    end

    // Stage registers: valid follows the ready chain, payload only moves with a real transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int j = 1; j < int'(N); j++) begin
                dat_q[j]  <= '0;
                idx_q[j]  <= '0;
                live_q[j] <= 1'b0;
            end
        end else begin
            v_q <= v_d;
            for (int s = 1; s <= int'(L); s++) begin
                if (load_c[s]) begin
                    for (int m = 0; m < int'(N >> s); m++) begin
                        dat_q[int'(N >> s) + m]  <= dat_d[int'(N >> s) + m];
                        idx_q[int'(N >> s) + m]  <= idx_d[int'(N >> s) + m];
                        live_q[int'(N >> s) + m] <= live_d[int'(N >> s) + m];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy_c[0];
    assign bus.out_valid = v_q[L];
    assign bus.out_data  = dat_q[1];
    assign bus.out_index = idx_q[1];
    assign bus.out_none  = v_q[L] & ~live_q[1];
endmodule

// File: tb/tb_max_tree_with_index.sv
// Bench for max_tree_with_index: directed cases, random stream vs lane-scan model, reset, 2-lane build.
module tb_max_tree_with_index;
    typedef struct {
        logic [7:0] d;
        logic [2:0] i;
        logic       n;
    } res_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    res_t qu[$];
    res_t qs[$];

    logic [7:0]  cu_d, cs_d;
    logic [2:0]  cu_i, cs_i;
    logic        cu_n, cs_n;

    logic [63:0] cd;
    logic [7:0]  cm;
    bit          cmn, have, ordy, stall_prev;
    int          sent, rcvd, cyc;
    res_t        e;
    logic [15:0] d1;
    logic [1:0]  m1;
    bit          mn1;

    max_tree_with_index_if #(.C_DATA_WIDTH(8), .C_INDEX_WIDTH(3)) bu ();
    max_tree_with_index_if #(.C_DATA_WIDTH(8), .C_INDEX_WIDTH(3)) bs ();
    max_tree_with_index_if #(.C_DATA_WIDTH(8), .C_INDEX_WIDTH(1)) b1 ();

    max_tree_with_index #(.C_DATA_WIDTH(8), .C_INDEX_WIDTH(3), .C_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .bus(bu));
    max_tree_with_index #(.C_DATA_WIDTH(8), .C_INDEX_WIDTH(3), .C_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .bus(bs));
    max_tree_with_index #(.C_DATA_WIDTH(8), .C_INDEX_WIDTH(1), .C_SIGNED(1'b0)) dut_1 (
        .clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: scan lanes in order; ties move the pick to the later lane.
    function automatic res_t ref_pick(input logic [63:0] d, input logic [7:0] m, input int n,
                                      input bit mn, input bit sg);
        res_t       r;
        int         best;
        int         bv;
        int         v;
        logic [7:0] lane;
        best = -1;
        bv   = 0;
        for (int k = 0; k < n; k++) begin
            if (m[k]) begin
                lane = d[k*8 +: 8];
                v    = sg ? int'($signed(lane)) : int'(lane);
                if (best < 0 || (mn ? (v <= bv) : (v >= bv))) begin
                    best = k;
                    bv   = v;
                end
            end
        end
        if (best < 0) begin
            r.d = 8'h00;
            r.i = 3'd0;
            r.n = 1'b1;
        end else begin
            r.d = d[best*8 +: 8];
            r.i = 3'(best);
            r.n = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [63:0] pk8(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [7:0] l3,
                                        input logic [7:0] l4, input logic [7:0] l5,
                                        input logic [7:0] l6, input logic [7:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv3(input bit v, input logic [63:0] d, input logic [7:0] m, input bit mn);
        bu.in_valid = v;  bs.in_valid = v;
        bu.in_data  = d;  bs.in_data  = d;
        bu.in_mask  = m;  bs.in_mask  = m;
        bu.in_min   = mn; bs.in_min   = mn;
    endtask

    task automatic set_ordy(input bit r);
        bu.out_ready = r;
        bs.out_ready = r;
    endtask

    // One isolated transaction on both 8-lane builds; checks latency and the model result.
    task automatic do_one(input string tag, input logic [63:0] d, input logic [7:0] m, input bit mn);
        res_t eu;
        res_t es;
        int   n;
        eu = ref_pick(d, m, 8, mn, 1'b0);
        es = ref_pick(d, m, 8, mn, 1'b1);
        @(negedge clk);
        drv3(1'b1, d, m, mn);
        set_ordy(1'b1);
        #1;
        chk({tag, ":in_ready"}, 32'(bs.in_ready), 32'd1);
        @(negedge clk);
        drv3(1'b0, 64'h0, 8'h00, 1'b0);
        n = 1;
        while (!bs.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'd3);
        cs_d = bs.out_data; cs_i = bs.out_index; cs_n = bs.out_none;
        cu_d = bu.out_data; cu_i = bu.out_index; cu_n = bu.out_none;
        chk({tag, ":u_valid"}, 32'(bu.out_valid), 32'd1);
        chk({tag, ":s_data"},  32'(cs_d), 32'(es.d));
        chk({tag, ":s_index"}, 32'(cs_i), 32'(es.i));
        chk({tag, ":s_none"},  32'(cs_n), 32'(es.n));
        chk({tag, ":u_data"},  32'(cu_d), 32'(eu.d));
        chk({tag, ":u_index"}, 32'(cu_i), 32'(eu.i));
        chk({tag, ":u_none"},  32'(cu_n), 32'(eu.n));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drv3(1'b0, 64'h0, 8'h00, 1'b0);
        set_ordy(1'b1);
        b1.in_valid = 1'b0; b1.in_data = 16'h0; b1.in_mask = 2'b00; b1.in_min = 1'b0;
        b1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bs.out_valid), 32'd0);
        chk("rst_out_data",  32'(bs.out_data),  32'd0);
        chk("rst_out_index", 32'(bs.out_index), 32'd0);
        chk("rst_out_none",  32'(bs.out_none),  32'd0);
        chk("rst_in_ready",  32'(bs.in_ready),  32'd1);
        chk("rst_b1_valid",  32'(b1.out_valid), 32'd0);

        // T1: unsigned max with duplicate maximum
        do_one("t1", pk8(8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7, 8'd5), 8'hFF, 1'b0);
        chk("t1_u_data",  32'(cu_d), 32'd9);
        chk("t1_u_index", 32'(cu_i), 32'd3);
        chk("t1_u_none",  32'(cu_n), 32'd0);
        chk("t1_s_index", 32'(cs_i), 32'd3);

        // T2: signed min, full and partial masks
        do_one("t2a", pk8(8'd5, 8'hFE, 8'hFE, 8'd0, 8'd7, 8'hFF, 8'd3, 8'd4), 8'hFF, 1'b1);
        chk("t2a_s_data",  32'(cs_d), 32'h0FE);
        chk("t2a_s_index", 32'(cs_i), 32'd2);
        do_one("t2b", pk8(8'd5, 8'hFE, 8'hFE, 8'd0, 8'd7, 8'hFF, 8'd3, 8'd4), 8'hF9, 1'b1);
        chk("t2b_s_data",  32'(cs_d), 32'h0FF);
        chk("t2b_s_index", 32'(cs_i), 32'd5);

        // T3: all lanes masked, then only the top lane live
        do_one("t3a", {$urandom, $urandom}, 8'h00, 1'b0);
        chk("t3a_s_none",  32'(cs_n), 32'd1);
        chk("t3a_s_data",  32'(cs_d), 32'd0);
        chk("t3a_s_index", 32'(cs_i), 32'd0);
        chk("t3a_u_none",  32'(cu_n), 32'd1);
        do_one("t3b", {$urandom, $urandom}, 8'h80, 1'($urandom_range(0, 1)));
        chk("t3b_s_index", 32'(cs_i), 32'd7);
        chk("t3b_u_index", 32'(cu_i), 32'd7);

        // T4: random stream with random backpressure against the in-order scoreboard
        sent = 0; rcvd = 0; cyc = 0; have = 1'b0; stall_prev = 1'b0;
        cd = 64'h0; cm = 8'h00; cmn = 1'b0;
        qu.delete();
        qs.delete();
        while (rcvd < 20 && cyc < 800) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < 20 && $urandom_range(0, 3) != 0) begin
                cd  = {$urandom, $urandom};
                cm  = 8'($urandom);
                if ($urandom_range(0, 7) == 0) cm = 8'h00;
                cmn = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            drv3(have, cd, cm, cmn);
            ordy = ($urandom_range(0, 1) == 1);
            set_ordy(ordy);
            #1;
            chk("t4_in_ready_s", 32'(bs.in_ready), 32'(!(qs.size() == 3 && !ordy)));
            chk("t4_in_ready_u", 32'(bu.in_ready), 32'(!(qu.size() == 3 && !ordy)));
            if (stall_prev) chk("t4_stall_valid", 32'(bs.out_valid), 32'd1);
            if (bs.out_valid) begin
                chk("t4_s_nonempty", 32'(qs.size() != 0), 32'd1);
                if (qs.size() != 0) begin
                    chk("t4_s_data",  32'(bs.out_data),  32'(qs[0].d));
                    chk("t4_s_index", 32'(bs.out_index), 32'(qs[0].i));
                    chk("t4_s_none",  32'(bs.out_none),  32'(qs[0].n));
                    if (ordy) begin
                        void'(qs.pop_front());
                        rcvd++;
                    end
                end
            end
            if (bu.out_valid) begin
                chk("t4_u_nonempty", 32'(qu.size() != 0), 32'd1);
                if (qu.size() != 0) begin
                    chk("t4_u_data",  32'(bu.out_data),  32'(qu[0].d));
                    chk("t4_u_index", 32'(bu.out_index), 32'(qu[0].i));
                    chk("t4_u_none",  32'(bu.out_none),  32'(qu[0].n));
                    if (ordy) void'(qu.pop_front());
                end
            end
            if (have && bs.in_ready) begin
                qs.push_back(ref_pick(cd, cm, 8, cmn, 1'b1));
                qu.push_back(ref_pick(cd, cm, 8, cmn, 1'b0));
                sent++;
                have = 1'b0;
            end
            stall_prev = bs.out_valid && !ordy;
        end
        chk("t4_received", 32'(rcvd), 32'd20);
        chk("t4_u_left",   32'(qu.size()), 32'd0);
        @(negedge clk);
        drv3(1'b0, 64'h0, 8'h00, 1'b0);
        set_ordy(1'b1);
        repeat (2) @(negedge clk);

        // T5: fill the pipe under backpressure, then reset mid-flight
        set_ordy(1'b0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            drv3(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0);
            #1;
            chk("t5_fill_ready", 32'(bs.in_ready), 32'd1);
        end
        @(negedge clk);
        drv3(1'b0, 64'h0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_out_valid", 32'(bs.out_valid), 32'd0);
        chk("t5_out_data",  32'(bs.out_data),  32'd0);
        chk("t5_out_index", 32'(bs.out_index), 32'd0);
        chk("t5_out_none",  32'(bs.out_none),  32'd0);
        chk("t5_in_ready",  32'(bs.in_ready),  32'd1);
        chk("t5_u_valid",   32'(bu.out_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("t5_no_stale", 32'(bs.out_valid), 32'd0);
        end
        do_one("t5_next", pk8(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80), 8'h3C, 1'b0);
        chk("t5_next_data",  32'(cs_d), 32'd60);
        chk("t5_next_index", 32'(cs_i), 32'd5);

        // T6: two-lane build, single registered compare
        for (int t = 0; t < 8; t++) begin
            if (t < 2) begin
                d1  = 16'h0404;
                m1  = 2'b11;
                mn1 = (t == 1);
            end else begin
                d1  = 16'($urandom);
                m1  = 2'($urandom);
                mn1 = 1'($urandom_range(0, 1));
            end
            e = ref_pick({48'h0, d1}, {6'h00, m1}, 2, mn1, 1'b0);
            @(negedge clk);
            b1.in_valid = 1'b1; b1.in_data = d1; b1.in_mask = m1; b1.in_min = mn1;
            b1.out_ready = 1'b1;
            #1;
            chk("t6_in_ready", 32'(b1.in_ready), 32'd1);
            @(negedge clk);
            b1.in_valid = 1'b0;
            chk("t6_valid", 32'(b1.out_valid), 32'd1);
            chk("t6_data",  32'(b1.out_data),  32'(e.d));
            chk("t6_index", 32'(b1.out_index), 32'(e.i));
            chk("t6_none",  32'(b1.out_none),  32'(e.n));
            if (t < 2) chk("t6_tie_index", 32'(b1.out_index), 32'd1);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
